// File: rtl/instr_mem_responder_pkg.sv
// Shared definitions for the instruction-memory responder.
// Contents: the responder FSM state enum, the default NOP word returned on
// fetch errors, the machine word width, and a fetch address check helper.
package pipeline_pkg;

  localparam int unsigned WORD_BITS = 32;

  // addi x0, x0, 0 -- harmless filler for faulted fetches
  localparam logic [WORD_BITS-1:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    IMEM_IDLE = 2'd0,
    IMEM_WAIT = 2'd1,
    IMEM_RESP = 2'd2
  } imem_state_e;

  // A fetch faults when the byte address is not word aligned or its word
  // index lies beyond the populated array.
  function automatic logic imem_fetch_err(input logic [WORD_BITS-1:0] pc,
                                          input int unsigned depth);
    return (pc[1:0] != 2'b00) || ({2'b00, pc[WORD_BITS-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// Fetch/load bus between the core (master) and the instruction memory
// responder (slave).
//   InstrMemRead/PC         : fetch strobe and byte address   (master -> slave)
//   LoadEn/LoadAddr/LoadData: backdoor word write             (master -> slave)
//   InstrMemData/Valid/Err  : fetch response                  (slave -> master)
//   InstrMemBusy            : request pending, new fetches ignored
interface instr_mem_responder_if;
  import pipeline_pkg::*;

  logic                 InstrMemRead;
  logic [WORD_BITS-1:0] PC;
  logic [WORD_BITS-1:0] InstrMemData;
  logic                 InstrMemValid;
  logic                 InstrMemErr;
  logic                 InstrMemBusy;
  logic                 LoadEn;
  logic [WORD_BITS-1:0] LoadAddr;
  logic [WORD_BITS-1:0] LoadData;

  modport master (
    output InstrMemRead, PC, LoadEn, LoadAddr, LoadData,
    input  InstrMemData, InstrMemValid, InstrMemErr, InstrMemBusy
  );

  modport slave (
    input  InstrMemRead, PC, LoadEn, LoadAddr, LoadData,
    output InstrMemData, InstrMemValid, InstrMemErr, InstrMemBusy
  );

endinterface

// File: rtl/instr_mem_responder_array.sv
// imem_array: instruction word storage with one write port and one
// synchronous read port. A read and a write to the same word on the same
// edge return the old word (read-before-write). Contents are never reset.
//   clk   : clock
//   we_i  : write enable, waddr_i/wdata_i : write word index / data
//   re_i  : read enable,  raddr_i : read word index
//   rdata_o : registered read data, updated on edges with re_i=1
module imem_array
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [WORD_BITS-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [AW-1:0]        raddr_i,
  output logic [WORD_BITS-1:0] rdata_o
);

  logic [WORD_BITS-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_BITS-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: answers instruction fetches from the core out of a
// locally held program image, with a backdoor load port to fill it.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : instr_mem_responder_if.slave (fetch request/response + load)
// Build option: define IMEM_WAIT_STATE_EN to insert WAIT_CYCLES wait states
// before each response (InstrMemBusy high meanwhile). Without it every fetch
// answers one cycle after the request and InstrMemBusy is constant 0.
module instr_mem_responder
  import pipeline_pkg::*;
#(
  parameter int unsigned          DEPTH_WORDS = 1024,
  parameter int unsigned          WAIT_CYCLES = 2,
  parameter logic [WORD_BITS-1:0] NOP_WORD    = NOP_WORD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_mem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

`ifdef IMEM_WAIT_STATE_EN
  localparam int unsigned EFF_W    = WAIT_CYCLES;
  localparam logic [3:0]  CNT_LOAD = (EFF_W == 0) ? 4'd0 : 4'(EFF_W - 1);
`endif

  imem_state_e          state_q, state_d;
  logic [WORD_BITS-1:0] pc_q, pc_d;
  logic [WORD_BITS-1:0] data_hold_q;
  logic                 err_hold_q;
  logic                 rd_en;
  logic [AW-1:0]        rd_idx;
  logic [WORD_BITS-1:0] rd_data;
  logic                 resp;
  logic                 fetch_err;
  logic [WORD_BITS-1:0] resp_data;
  logic                 ld_en;

`ifdef IMEM_WAIT_STATE_EN
  logic [3:0]           cnt_q, cnt_d;
`endif

  // The array is read on the edge that enters RESP, so the word is on
  // rd_data for the whole RESP cycle. With no wait states that edge is the
  // request edge itself, hence the read index comes straight from PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rd_en   = 1'b0;
    rd_idx  = bus.PC[AW+1:2];
`ifdef IMEM_WAIT_STATE_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IMEM_IDLE, IMEM_RESP: begin
        if (bus.InstrMemRead) begin
          pc_d = bus.PC;
`ifdef IMEM_WAIT_STATE_EN
          if (EFF_W != 0) begin
            state_d = IMEM_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = IMEM_RESP;
            rd_en   = 1'b1;
          end
`else
          state_d = IMEM_RESP;
          rd_en   = 1'b1;
`endif
        end else begin
          state_d = IMEM_IDLE;
        end
      end
`ifdef IMEM_WAIT_STATE_EN
      IMEM_WAIT: begin
        // fetch strobes are ignored here; only the latched PC is served
        if (cnt_q == 4'd0) begin
          state_d = IMEM_RESP;
          rd_en   = 1'b1;
          rd_idx  = pc_q[AW+1:2];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      default: state_d = IMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IMEM_IDLE;
      pc_q        <= '0;
      data_hold_q <= '0;
      err_hold_q  <= 1'b0;
`ifdef IMEM_WAIT_STATE_EN
      cnt_q       <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef IMEM_WAIT_STATE_EN
      cnt_q   <= cnt_d;
`endif
      // remember the response so Data/Err stay put between pulses
      if (resp) begin
        data_hold_q <= resp_data;
        err_hold_q  <= fetch_err;
      end
    end
  end

  // out-of-range loads are dropped rather than aliased onto low words
  assign ld_en = bus.LoadEn && !rst && (bus.LoadAddr < WORD_BITS'(DEPTH_WORDS));

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (ld_en),
    .waddr_i (bus.LoadAddr[AW-1:0]),
    .wdata_i (bus.LoadData),
    .re_i    (rd_en),
    .raddr_i (rd_idx),
    .rdata_o (rd_data)
  );

  assign resp      = (state_q == IMEM_RESP);
  assign fetch_err = imem_fetch_err(pc_q, DEPTH_WORDS);
  assign resp_data = fetch_err ? NOP_WORD : rd_data;

  assign bus.InstrMemValid = resp;
  assign bus.InstrMemData  = resp ? resp_data : data_hold_q;
  assign bus.InstrMemErr   = resp ? fetch_err : err_hold_q;
`ifdef IMEM_WAIT_STATE_EN
  assign bus.InstrMemBusy  = (state_q == IMEM_WAIT);
`else
  assign bus.InstrMemBusy  = 1'b0;
`endif

endmodule
